// File: rtl/square_scheduler_pkg.sv
// square_scheduler_pkg: shared state encodings, object record and screen constants.
// is_offscreen is used only when SCHED_CULL_EN is defined.
package square_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DRAW = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic [8:0] x;
    logic [8:0] y;
    logic [5:0] depth;
  } obj_t;

  localparam int OBJ_W     = $bits(obj_t);
  localparam int X_MAX     = 128;
  localparam int Y_MAX     = 64;
  localparam int DEPTH_MAX = 63;

  // Half-size grows as depth shrinks; the square is gone once its center clears the far edge by that much.
  function automatic logic is_offscreen(input logic [8:0] x, input logic [8:0] y,
                                        input logic [5:0] depth);
    logic [9:0] half;
    half = 10'(DEPTH_MAX) - {4'd0, depth};
    return ({1'b0, x} >= 10'(X_MAX) + half) || ({1'b0, y} >= 10'(Y_MAX) + half);
  endfunction

endpackage

// File: rtl/square_scheduler_obj_table.sv
// square_scheduler_obj_table: object store with one write port, one registered read port,
// per-entry valid bits and a per-frame drawn mask (flags reset by the active-low reset).
module square_scheduler_obj_table
  import square_scheduler_pkg::*;
#(
  parameter int NUM_OBJ = 8,
  parameter int IDX_W   = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_addr,
  input  logic [OBJ_W-1:0]   wr_data,
  input  logic               wr_valid,
  input  logic [IDX_W-1:0]   rd_addr,
  output logic [OBJ_W-1:0]   rd_data,
  output logic [NUM_OBJ-1:0] valid,
  output logic [NUM_OBJ-1:0] drawn,
  input  logic               drawn_clr,
  input  logic               drawn_set,
  input  logic [IDX_W-1:0]   drawn_idx
);

  logic [OBJ_W-1:0]   mem [NUM_OBJ];
  logic [OBJ_W-1:0]   rd_data_reg;
  logic [NUM_OBJ-1:0] valid_reg;
  logic [NUM_OBJ-1:0] drawn_reg;

  // Payload has no reset so it maps onto RAM; only the flags need clearing.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_reg <= mem[rd_addr];
  end

  for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_flags
    always_ff @(posedge clock) begin
      if (!reset) begin
        valid_reg[gi] <= 1'b0;
        drawn_reg[gi] <= 1'b0;
      end else begin
        if (wr_en && (wr_addr == IDX_W'(gi))) begin
          valid_reg[gi] <= wr_valid;
        end
        if (drawn_clr) begin
          drawn_reg[gi] <= 1'b0;
        end else if (drawn_set && (drawn_idx == IDX_W'(gi))) begin
          drawn_reg[gi] <= 1'b1;
        end
      end
    end
  end

  assign rd_data = rd_data_reg;
  assign valid   = valid_reg;
  assign drawn   = drawn_reg;

endmodule

// File: rtl/square_scheduler.sv
// square_scheduler: per frame, issues valid squares to the edge calculator farthest-first.
// Define SCHED_CULL_EN to skip wholly off-screen squares and expose cull_count.
module square_scheduler
  import square_scheduler_pkg::*;
#(
  parameter int NUM_OBJ = 8,
  parameter int IDX_W   = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             frame_start,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [8:0]       wr_x,
  input  logic [8:0]       wr_y,
  input  logic [5:0]       wr_depth,
  input  logic             wr_valid,
  input  logic             ec_donesquare,
  output logic             ec_enable,
  output logic [8:0]       ec_xcenter,
  output logic [8:0]       ec_ycenter,
  output logic [5:0]       ec_depth,
  output logic             busy,
  output logic             frame_done,
  output logic             wr_err
`ifdef SCHED_CULL_EN
  ,
  output logic [7:0]       cull_count
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);

  sched_state_t     state_reg, state_next;
  logic [IDX_W-1:0] scan_idx_reg, scan_idx_next;
  logic [IDX_W-1:0] cmp_idx_reg, cmp_idx_next;
  logic [IDX_W-1:0] best_idx_reg, best_idx_next;
  logic             fetch_done_reg, fetch_done_next;
  logic             cmp_vld_reg, cmp_vld_next;
  logic             best_found_reg, best_found_next;
  obj_t             best_reg, best_next;
  obj_t             ec_obj_reg, ec_obj_next;
  logic             ec_enable_reg, ec_enable_next;
  logic             busy_reg, busy_next;
  logic             frame_done_reg, frame_done_next;
  logic             wr_err_reg, wr_err_next;

  obj_t             rd_obj;
  obj_t             wr_obj;
  logic [OBJ_W-1:0] rd_data;
  logic [NUM_OBJ-1:0] valid;
  logic [NUM_OBJ-1:0] drawn;
  logic             drawn_clr, drawn_set;
  logic [IDX_W-1:0] drawn_idx;
  logic             wr_accept, cand, cull, take;

  assign wr_accept = wr_en && !busy_reg;
  assign wr_obj    = '{x: wr_x, y: wr_y, depth: wr_depth};
  assign rd_obj    = obj_t'(rd_data);

  square_scheduler_obj_table #(
    .NUM_OBJ(NUM_OBJ),
    .IDX_W  (IDX_W)
  ) u_obj_table (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_accept),
    .wr_addr  (wr_addr),
    .wr_data  (wr_obj),
    .wr_valid (wr_valid),
    .rd_addr  (scan_idx_reg),
    .rd_data  (rd_data),
    .valid    (valid),
    .drawn    (drawn),
    .drawn_clr(drawn_clr),
    .drawn_set(drawn_set),
    .drawn_idx(drawn_idx)
  );

  // rd_obj holds entry cmp_idx_reg whenever cmp_vld_reg is set (one-cycle read latency).
  assign cand = cmp_vld_reg && valid[cmp_idx_reg] && !drawn[cmp_idx_reg];

`ifdef SCHED_CULL_EN
  logic [7:0] cull_count_reg, cull_count_next;
  assign cull       = cand && is_offscreen(rd_obj.x, rd_obj.y, rd_obj.depth);
  assign cull_count = cull_count_reg;
`else
  assign cull = 1'b0;
`endif

  assign take = cand && !cull && (!best_found_reg || (rd_obj.depth > best_reg.depth));

  always_comb begin
    state_next      = state_reg;
    scan_idx_next   = scan_idx_reg;
    cmp_idx_next    = cmp_idx_reg;
    best_idx_next   = best_idx_reg;
    fetch_done_next = fetch_done_reg;
    cmp_vld_next    = 1'b0;
    best_found_next = best_found_reg;
    best_next       = best_reg;
    ec_obj_next     = ec_obj_reg;
    ec_enable_next  = ec_enable_reg;
    busy_next       = busy_reg;
    frame_done_next = 1'b0;
    wr_err_next     = wr_en && busy_reg;
    drawn_clr       = 1'b0;
    drawn_set       = 1'b0;
    drawn_idx       = cmp_idx_reg;
`ifdef SCHED_CULL_EN
    cull_count_next = cull_count_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (frame_start) begin
          state_next      = SCAN;
          busy_next       = 1'b1;
          drawn_clr       = 1'b1;
          best_found_next = 1'b0;
          scan_idx_next   = '0;
          fetch_done_next = 1'b0;
`ifdef SCHED_CULL_EN
          cull_count_next = 8'd0;
`endif
        end
      end

      SCAN: begin
        if (!fetch_done_reg) begin
          cmp_vld_next    = 1'b1;
          cmp_idx_next    = scan_idx_reg;
          scan_idx_next   = scan_idx_reg + IDX_W'(1);
          fetch_done_next = (scan_idx_reg == LAST_IDX);
        end
        if (cull) begin
          drawn_set = 1'b1;
`ifdef SCHED_CULL_EN
          if (cull_count_reg != 8'hFF) begin
            cull_count_next = cull_count_reg + 8'd1;
          end
`endif
        end
        if (take) begin
          best_found_next = 1'b1;
          best_idx_next   = cmp_idx_reg;
          best_next       = rd_obj;
        end
        if (cmp_vld_reg && (cmp_idx_reg == LAST_IDX)) begin
          if (best_found_next) begin
            ec_obj_next    = best_next;
            ec_enable_next = 1'b1;
            state_next     = DRAW;
          end else begin
            frame_done_next = 1'b1;
            busy_next       = 1'b0;
            state_next      = IDLE;
          end
        end
      end

      DRAW: begin
        // scan_idx has wrapped to 0, so entry 0 is already on rd_obj: restart with it in compare.
        if (ec_donesquare) begin
          drawn_set       = 1'b1;
          drawn_idx       = best_idx_reg;
          best_found_next = 1'b0;
          ec_enable_next  = 1'b0;
          state_next      = SCAN;
          cmp_vld_next    = 1'b1;
          cmp_idx_next    = '0;
          scan_idx_next   = IDX_W'(1);
          fetch_done_next = 1'b0;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg      <= IDLE;
      scan_idx_reg   <= '0;
      cmp_idx_reg    <= '0;
      best_idx_reg   <= '0;
      fetch_done_reg <= 1'b0;
      cmp_vld_reg    <= 1'b0;
      best_found_reg <= 1'b0;
      best_reg       <= '0;
      ec_obj_reg     <= '0;
      ec_enable_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      wr_err_reg     <= 1'b0;
`ifdef SCHED_CULL_EN
      cull_count_reg <= 8'd0;
`endif
    end else begin
      state_reg      <= state_next;
      scan_idx_reg   <= scan_idx_next;
      cmp_idx_reg    <= cmp_idx_next;
      best_idx_reg   <= best_idx_next;
      fetch_done_reg <= fetch_done_next;
      cmp_vld_reg    <= cmp_vld_next;
      best_found_reg <= best_found_next;
      best_reg       <= best_next;
      ec_obj_reg     <= ec_obj_next;
      ec_enable_reg  <= ec_enable_next;
      busy_reg       <= busy_next;
      frame_done_reg <= frame_done_next;
      wr_err_reg     <= wr_err_next;
`ifdef SCHED_CULL_EN
      cull_count_reg <= cull_count_next;
`endif
    end
  end

  assign ec_enable  = ec_enable_reg;
  assign ec_xcenter = ec_obj_reg.x;
  assign ec_ycenter = ec_obj_reg.y;
  assign ec_depth   = ec_obj_reg.depth;
  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;
  assign wr_err     = wr_err_reg;

endmodule
